// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: debounce default, timing helper, FSM encoding.
package btn_pkg;

  localparam int CLK_HZ               = 50_000_000;
  localparam int CYCLES_PER_MS        = CLK_HZ / 1000;
  localparam int DEBOUNCE_CYCLES_DEF  = CYCLES_PER_MS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM/counter, registered press/release pulses.
// btn changes SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first edge that samples a stable raw level.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [0:0]             state;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Any agreement with the current output during COUNT restarts the whole qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      btn   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync != btn) begin
            state <= ST_COUNT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_COUNT: begin
          if (sync == btn) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            btn   <= sync;
            rise  <= sync;
            fall  <= ~sync;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN-channel push-button conditioner feeding the GPIO button inputs with clean levels and edge pulses.
// Optional sticky press flags and irq are built only when BTN_EVENT_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] rise_o,
  output logic [N_BTN-1:0] fall_o,
  input  logic [N_BTN-1:0] evt_clr_i,
  output logic [N_BTN-1:0] evt_o,
  output logic             irq_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
    $error("btn_conditioner: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw_i[i]),
      .btn    (btn_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i])
    );
  end

`ifdef BTN_EVENT_EN
  logic [N_BTN-1:0] evt_q;
  logic [N_BTN-1:0] evt_nxt;
  logic             irq_q;

  // A press arriving with its clear keeps the flag set.
  assign evt_nxt = (evt_q & ~evt_clr_i) | rise_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_nxt;
      irq_q <= |evt_nxt;
    end
  end

  assign evt_o = evt_q;
  assign irq_o = irq_q;
`else
  logic unused_evt_clr;
  assign unused_evt_clr = ^evt_clr_i;
  assign evt_o = '0;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2; directed scenarios plus randomized run vs window model.
module tb_btn_conditioner;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int LAT = SS + DC + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw_i = '0;
  logic [N-1:0] evt_clr_i = '0;
  logic [N-1:0] btn_o, rise_o, fall_o, evt_o;
  logic         irq_o;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SS), .CNT_W(16), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw_i(btn_raw_i), .btn_o(btn_o), .rise_o(rise_o),
    .fall_o(fall_o), .evt_clr_i(evt_clr_i), .evt_o(evt_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Reference: the level seen by the debouncer at an edge is the raw value captured SS edges earlier;
  // the output flips when the last DC+1 seen values all disagree with it.
  logic [N-1:0] rawhist[$];
  logic [N-1:0] win[$];
  logic [N-1:0] m_btn, m_rise, m_fall, m_evt, nb, nr, nf, ne, seen;
  logic         m_irq, alldiff;

  always @(posedge clk) begin
    if (rst) begin
      rawhist.delete();
      win.delete();
      m_btn = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
    end else begin
      seen = (rawhist.size() >= SS) ? rawhist[rawhist.size()-SS] : '0;
      rawhist.push_back(btn_raw_i);
      if (rawhist.size() > SS) void'(rawhist.pop_front());
      win.push_back(seen);
      if (win.size() > DC + 1) void'(win.pop_front());
      ne = (m_evt & ~evt_clr_i) | m_rise;
      nb = m_btn; nr = '0; nf = '0;
      if (win.size() == DC + 1) begin
        for (int c = 0; c < N; c++) begin
          alldiff = 1'b1;
          foreach (win[j]) if (win[j][c] == m_btn[c]) alldiff = 1'b0;
          if (alldiff) begin
            nb[c] = ~m_btn[c];
            nr[c] = ~m_btn[c];
            nf[c] = m_btn[c];
          end
        end
      end
      m_btn = nb; m_rise = nr; m_fall = nf;
`ifdef BTN_EVENT_EN
      m_evt = ne; m_irq = |ne;
`else
      m_evt = '0; m_irq = 1'b0;
`endif
    end
  end

  task automatic apply_reset();
    rst = 1'b1; btn_raw_i = '0; evt_clr_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_raw_i = 4'($urandom); evt_clr_i = '0;
    @(posedge clk); #1;
    checks++; if (btn_o !== 4'b0)  begin errors++; $display("FAIL reset_btn got %b want 0000", btn_o); end
    checks++; if (rise_o !== 4'b0) begin errors++; $display("FAIL reset_rise got %b want 0000", rise_o); end
    checks++; if (fall_o !== 4'b0) begin errors++; $display("FAIL reset_fall got %b want 0000", fall_o); end
    checks++; if (evt_o !== 4'b0)  begin errors++; $display("FAIL reset_evt got %b want 0000", evt_o); end
    checks++; if (irq_o !== 1'b0)  begin errors++; $display("FAIL reset_irq got %b want 0", irq_o); end
  endtask

  task automatic test_press_latency();
    int n = 0;
    apply_reset();
    btn_raw_i = 4'b0001;
    do begin @(posedge clk); #1; n++; end while (btn_o[0] !== 1'b1 && n < 30);
    checks++; if (n != LAT) begin errors++; $display("FAIL press_latency got %0d want %0d", n, LAT); end
    checks++; if (rise_o !== 4'b0001) begin errors++; $display("FAIL press_rise got %b want 0001", rise_o); end
    checks++; if (btn_o !== 4'b0001) begin errors++; $display("FAIL press_others got %b want 0001", btn_o); end
    @(posedge clk); #1;
    checks++; if (rise_o !== 4'b0) begin errors++; $display("FAIL press_rise_width got %b want 0000", rise_o); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    apply_reset();
    btn_raw_i = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 2) btn_raw_i = 4'b0000;
      pulses += int'(rise_o[1]) + int'(fall_o[1]) + int'(btn_o[1]);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_reject got %0d activity want 0", pulses); end
  endtask

  task automatic test_chatter();
    logic [9:0] pat = 10'b1111101101;  // applied LSB first: 1,0,1,1,0,1,1,1,1,1
    int rises = 0, at = -1;
    apply_reset();
    for (int e = 1; e <= 30; e++) begin
      if (e <= 10) btn_raw_i = {1'b0, pat[e-1], 2'b00};
      @(posedge clk); #1;
      if (rise_o[2]) begin rises++; at = e; end
    end
    checks++; if (rises != 1) begin errors++; $display("FAIL chatter_count got %0d want 1", rises); end
    // final run begins with element 6, sampled on edge 6
    checks++; if (at != 6 + LAT - 1) begin errors++; $display("FAIL chatter_edge got %0d want %0d", at, 6 + LAT - 1); end
  endtask

  task automatic test_release();
    int n = 0, rises = 0, falls = 0;
    apply_reset();
    btn_raw_i = 4'b1000;
    repeat (LAT + 3) begin @(posedge clk); #1; rises += int'(rise_o[3]); falls += int'(fall_o[3]); end
    btn_raw_i = 4'b0000;
    do begin @(posedge clk); #1; n++; rises += int'(rise_o[3]); falls += int'(fall_o[3]); end
      while (fall_o[3] !== 1'b1 && n < 30);
    checks++; if (n != LAT) begin errors++; $display("FAIL release_latency got %0d want %0d", n, LAT); end
    checks++; if (btn_o[3] !== 1'b0) begin errors++; $display("FAIL release_btn got %b want 0", btn_o[3]); end
    repeat (10) begin @(posedge clk); #1; rises += int'(rise_o[3]); falls += int'(fall_o[3]); end
    checks++; if (rises != 1 || falls != 1) begin errors++; $display("FAIL release_pulses got rise=%0d fall=%0d want 1/1", rises, falls); end
  endtask

  task automatic test_reset_midcount();
    int n = 0;
    apply_reset();
    btn_raw_i = 4'b0001;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({btn_o, rise_o, fall_o, evt_o, irq_o} !== '0) begin
      errors++; $display("FAIL midcount_reset got btn=%b rise=%b fall=%b evt=%b irq=%b want zeros", btn_o, rise_o, fall_o, evt_o, irq_o);
    end
    rst = 1'b0;
    do begin @(posedge clk); #1; n++; end while (rise_o[0] !== 1'b1 && n < 30);
    checks++; if (n != LAT) begin errors++; $display("FAIL midcount_latency got %0d want %0d", n, LAT); end
  endtask

  task automatic test_events();
    apply_reset();
`ifdef BTN_EVENT_EN
    btn_raw_i = 4'b0011;
    repeat (LAT + 1) @(posedge clk);
    #1;
    checks++; if (evt_o !== 4'b0011) begin errors++; $display("FAIL evt_set got %b want 0011", evt_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL evt_irq got %b want 1", irq_o); end
    btn_raw_i = 4'b0010;
    repeat (LAT + 2) @(posedge clk);
    #1 btn_raw_i = 4'b0011;
    repeat (LAT) @(posedge clk);
    #1;
    checks++; if (rise_o[0] !== 1'b1) begin errors++; $display("FAIL evt_repress_rise got %b want 1", rise_o[0]); end
    evt_clr_i = 4'b0001;
    @(posedge clk); #1 evt_clr_i = '0;
    checks++; if (evt_o !== 4'b0011) begin errors++; $display("FAIL evt_set_wins got %b want 0011", evt_o); end
    evt_clr_i = 4'b0011;
    @(posedge clk); #1 evt_clr_i = '0;
    checks++; if (evt_o !== 4'b0000) begin errors++; $display("FAIL evt_clear got %b want 0000", evt_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL evt_irq_clear got %b want 0", irq_o); end
`else
    btn_raw_i = 4'b1111;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      evt_clr_i = 4'($urandom);
      checks++; if (evt_o !== 4'b0 || irq_o !== 1'b0) begin
        errors++; $display("FAIL evt_disabled got evt=%b irq=%b want 0000/0", evt_o, irq_o);
      end
    end
    evt_clr_i = '0;
`endif
  endtask

  task automatic test_random();
    int hold[N];
    apply_reset();
    for (int c = 0; c < N; c++) hold[c] = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      checks++; if (btn_o !== m_btn || rise_o !== m_rise || fall_o !== m_fall) begin
        errors++; $display("FAIL rand_levels cyc %0d got btn=%b rise=%b fall=%b want %b %b %b",
                           cyc, btn_o, rise_o, fall_o, m_btn, m_rise, m_fall);
      end
      checks++; if (evt_o !== m_evt || irq_o !== m_irq) begin
        errors++; $display("FAIL rand_evt cyc %0d got evt=%b irq=%b want %b %b", cyc, evt_o, irq_o, m_evt, m_irq);
      end
      checks++; if ((rise_o & fall_o) !== 4'b0) begin
        errors++; $display("FAIL rand_exclusive cyc %0d got rise&fall=%b want 0000", cyc, rise_o & fall_o);
      end
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          btn_raw_i[c] = ~btn_raw_i[c];
          hold[c] = int'($urandom_range(1, 9));
        end
      end
      evt_clr_i = 4'($urandom) & 4'($urandom) & 4'($urandom);
    end
    evt_clr_i = '0;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_chatter();
    test_release();
    test_reset_midcount();
    test_events();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
